image_ram_sequencer: RTL
========================

Name: image_ram_sequencer

Overview:
- Phase controller and arbiter for the single-port image RAM shared by three requesters: the UART loader, the downsampling processor and the UART retriever.
- Sequences the phases LOAD -> PROC -> READY -> SEND.
- Grants the RAM port to the owner of the current phase and drives a registered address/data/wren bus into the RAM.
- Tags read returns per requester and services an optional host debug read port in spare cycles.

Parameters:
- ADDR_W, 16, RAM address width
- DATA_W, 8, RAM data width
- RD_LAT, 1, RAM read latency in clk cycles from registered address to valid q

Ports:
- clk  in  1  system clock (PLL output)
- rst_n  in  1  asynchronous active-low reset
- ld_req  in  1  loader write request
- ld_addr  in  ADDR_W  loader address
- ld_data  in  DATA_W  loader write data
- ld_done  in  1  loader finished image (level)
- pr_req  in  1  processor access request
- pr_we  in  1  processor write (1) / read (0)
- pr_addr  in  ADDR_W  processor address
- pr_data  in  DATA_W  processor write data
- pr_done  in  1  processor finished (level)
- tx_req  in  1  retriever read request
- tx_addr  in  ADDR_W  retriever address
- tx_done  in  1  retriever finished (level)
- send_start_n  in  1  active-low request to transmit the image
- restart  in  1  pulse: return to LOAD from READY
- dbg_req  in  1  host debug read request
- dbg_addr  in  ADDR_W  debug address
- ld_gnt, pr_gnt, tx_gnt, dbg_gnt  out  1 each  combinational grant, same cycle as request
- ram_addr  out  ADDR_W  registered RAM address
- ram_data  out  DATA_W  registered RAM write data
- ram_wren  out  1  registered RAM write enable
- ram_q  in  DATA_W  RAM read data
- rd_data  out  DATA_W  registered copy of ram_q
- pr_rvalid, tx_rvalid, dbg_rvalid  out  1 each  read-return strobes
- proc_go  out  1  1-cycle pulse on entering PROC
- send_go  out  1  1-cycle pulse on entering SEND
- phase  out  2  00 LOAD, 01 PROC, 10 READY, 11 SEND
- phase_err  out  1  sticky: request seen outside the requester's phase

Behaviour:
- Reset (async, rst_n=0):
  - phase=LOAD; all grants, rvalids, proc_go, send_go, ram_wren and phase_err are 0.
  - ram_addr and ram_data are 0; the read-tag pipeline is cleared.
- FSM transitions (registered):
  - LOAD -> PROC on ld_done=1; proc_go=1 for the first PROC cycle.
  - PROC -> READY on pr_done=1.
  - READY -> SEND on send_start_n=0; send_go=1 for the first SEND cycle.
  - SEND -> READY on tx_done=1. Resend is allowed.
  - READY -> LOAD on restart=1.
  - If restart and send_start_n=0 arrive together, restart wins.
  - restart is ignored outside READY.
- Phase ownership:
  - LOAD: ld. PROC: pr. SEND: tx. READY: no owner.
  - The owner's grant equals its request.
  - A non-owner request gets no grant and sets phase_err. phase_err clears only on reset.
- Debug port:
  - In READY, dbg_gnt = dbg_req.
  - In other phases, dbg_gnt = dbg_req and not owner_req. The owner always wins a same-cycle conflict.
  - A denied dbg_req does not set phase_err.
- RAM bus: on each clk edge, register the granted requester's addr/data/we. When no grant is active, ram_wren=0 and ram_addr holds its previous value.
- ld is write-only; tx and dbg are read-only.
- Read return timing: a granted read in cycle N gives rd_data valid with the matching rvalid in cycle N+1+RD_LAT+1 (N+3 for the default RD_LAT=1).
  - The tag pipeline has depth RD_LAT+2 and tracks reads back-to-back, one per cycle.
- Phase change with reads in flight: outstanding tags still complete.
- Reset with reads in flight: the reads are dropped.
- Done inputs asserted in the same cycle as the owner's request: that request is still granted and serviced; the transition takes effect next cycle.

Optional Feature:
- Macro: RAMSEQ_DBG_PORT_EN.
- Defined: the debug port works as specified above.
- Undefined:
  - dbg_gnt and dbg_rvalid are tied 0.
  - dbg_req and dbg_addr are ignored.
  - The tag pipeline carries only pr and tx tags.

Test Plan:
- Reset, then ld writes 0xA5 to addr 0x0010 with ld_req=1 for 1 cycle -> next cycle ram_wren=1, ram_addr=0x0010, ram_data=0xA5. Then ld_done=1 -> phase=01 and proc_go high for exactly 1 cycle.
- In PROC, pr read of 0x0010 at cycle N -> pr_rvalid=1 and rd_data=0xA5 at N+3. Back-to-back reads of 0x0010 and 0x0011 -> two consecutive pr_rvalid cycles, in order.
- In PROC, pr_req and dbg_req in the same cycle -> pr_gnt=1, dbg_gnt=0. Next cycle with pr_req=0 -> dbg_gnt=1 and dbg_rvalid 3 cycles later.
- In LOAD, tx_req=1 -> tx_gnt=0, ram_wren unchanged, phase_err=1 and stays 1 after the phase changes.
- In READY, send_start_n=0 -> phase=11 with a 1-cycle send_go. tx_done -> READY. Then restart and send_start_n=0 together -> phase=00.
- Drive rst_n low mid-SEND with a read outstanding -> all outputs go to 0 immediately, phase=00, and no tx_rvalid appears after rst_n is released.

Source files
------------

// File: rtl/image_ram_sequencer.sv
// rtl/image_ram_sequencer.sv - phase sequencer and arbiter for the shared single-port image RAM
// Optional host debug read port enabled by defining RAMSEQ_DBG_PORT_EN.
module image_ram_sequencer #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_done,
    input  logic              pr_req,
    input  logic              pr_we,
    input  logic [ADDR_W-1:0] pr_addr,
    input  logic [DATA_W-1:0] pr_data,
    input  logic              pr_done,
    input  logic              tx_req,
    input  logic [ADDR_W-1:0] tx_addr,
    input  logic              tx_done,
    input  logic              send_start_n,
    input  logic              restart,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              ld_gnt,
    output logic              pr_gnt,
    output logic              tx_gnt,
    output logic              dbg_gnt,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    output logic [DATA_W-1:0] rd_data,
    output logic              pr_rvalid,
    output logic              tx_rvalid,
    output logic              dbg_rvalid,
    output logic              proc_go,
    output logic              send_go,
    output logic [1:0]        phase,
    output logic              phase_err
);

    typedef enum logic [1:0] {
        PH_LOAD  = 2'b00,
        PH_PROC  = 2'b01,
        PH_READY = 2'b10,
        PH_SEND  = 2'b11
    } phase_t;

    // One stage per cycle from grant to rd_data: address register, RD_LAT, rd_data register.
    localparam int TAG_D = RD_LAT + 2;

    phase_t state;
    phase_t state_next;
    logic   proc_go_next;
    logic   send_go_next;

    logic in_load;
    logic in_proc;
    logic in_send;
    logic owner_req;
    logic misuse;

    logic [TAG_D-1:0] pr_tag;
    logic [TAG_D-1:0] tx_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= PH_LOAD;
            proc_go <= 1'b0;
            send_go <= 1'b0;
        end else begin
            state   <= state_next;
            proc_go <= proc_go_next;
            send_go <= send_go_next;
        end
    end

    always_comb begin
        state_next   = state;
        proc_go_next = 1'b0;
        send_go_next = 1'b0;
        case (state)
            PH_LOAD: begin
                if (ld_done) begin
                    state_next   = PH_PROC;
                    proc_go_next = 1'b1;
                end
            end
            PH_PROC: begin
                if (pr_done) begin
                    state_next = PH_READY;
                end
            end
            PH_READY: begin
                // restart takes precedence over a simultaneous send request
                if (restart) begin
                    state_next = PH_LOAD;
                end else if (!send_start_n) begin
                    state_next   = PH_SEND;
                    send_go_next = 1'b1;
                end
            end
            PH_SEND: begin
                if (tx_done) begin
                    state_next = PH_READY;
                end
            end
            default: state_next = PH_LOAD;
        endcase
    end

    assign phase   = state;
    assign in_load = (state == PH_LOAD);
    assign in_proc = (state == PH_PROC);
    assign in_send = (state == PH_SEND);

    assign ld_gnt    = rst_n & in_load & ld_req;
    assign pr_gnt    = rst_n & in_proc & pr_req;
    assign tx_gnt    = rst_n & in_send & tx_req;
    assign owner_req = (in_load & ld_req) | (in_proc & pr_req) | (in_send & tx_req);
    assign misuse    = (ld_req & ~in_load) | (pr_req & ~in_proc) | (tx_req & ~in_send);

`ifdef RAMSEQ_DBG_PORT_EN
    logic [TAG_D-1:0] dbg_tag;

    assign dbg_gnt    = rst_n & dbg_req & ~owner_req;
    assign dbg_rvalid = dbg_tag[TAG_D-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_tag <= '0;
        end else begin
            dbg_tag <= {dbg_tag[TAG_D-2:0], dbg_gnt};
        end
    end
`else
    logic unused_dbg;

    assign dbg_gnt    = 1'b0;
    assign dbg_rvalid = 1'b0;
    assign unused_dbg = dbg_req ^ (^dbg_addr);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_err <= 1'b0;
        end else if (misuse) begin
            phase_err <= 1'b1;
        end
    end

    // Address holds when idle; only write enable drops back to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_addr <= '0;
            ram_data <= '0;
            ram_wren <= 1'b0;
        end else begin
            ram_wren <= 1'b0;
            if (ld_gnt) begin
                ram_addr <= ld_addr;
                ram_data <= ld_data;
                ram_wren <= 1'b1;
            end else if (pr_gnt) begin
                ram_addr <= pr_addr;
                ram_data <= pr_data;
                ram_wren <= pr_we;
            end else if (tx_gnt) begin
                ram_addr <= tx_addr;
            end
`ifdef RAMSEQ_DBG_PORT_EN
            else if (dbg_gnt) begin
                ram_addr <= dbg_addr;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pr_tag  <= '0;
            tx_tag  <= '0;
            rd_data <= '0;
        end else begin
            pr_tag  <= {pr_tag[TAG_D-2:0], pr_gnt & ~pr_we};
            tx_tag  <= {tx_tag[TAG_D-2:0], tx_gnt};
            rd_data <= ram_q;
        end
    end

    assign pr_rvalid = pr_tag[TAG_D-1];
    assign tx_rvalid = tx_tag[TAG_D-1];

endmodule
